// File: rtl/ptw_entry_builder.sv
// Purpose: turns a PTW Sv32 leaf response plus a PMA lookup into a packed TLB entry; optional PMA timeout via PTW_ENTRY_BUILDER_TIMEOUT_EN.
// Latency: PMA request 1 cycle after accept, entry valid 1 cycle after the PMA response (3-cycle minimum request spacing).
// Backpressure: one entry in flight; req_ready only in IDLE, entry held frozen in OUT until io_y_ready.
module ptw_entry_builder #(
    parameter int PMA_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [31:0] io_req_pte,
    input  logic        io_req_level,
    input  logic [19:0] io_req_vpn,
    input  logic        io_req_ae,
    output logic        io_pma_req_valid,
    output logic [31:0] io_pma_req_addr,
    input  logic        io_pma_resp_valid,
    input  logic        io_pma_resp_hit,
    input  logic        io_pma_resp_r,
    input  logic        io_pma_resp_w,
    input  logic        io_pma_resp_x,
    input  logic        io_pma_resp_pp,
    input  logic        io_pma_resp_al,
    input  logic        io_pma_resp_aa,
    input  logic        io_pma_resp_eff,
    input  logic        io_pma_resp_c,
    output logic        io_y_valid,
    input  logic        io_y_ready,
    output logic [19:0] io_y_ppn,
    output logic        io_y_u,
    output logic        io_y_ae,
    output logic        io_y_sw,
    output logic        io_y_sx,
    output logic        io_y_sr,
    output logic        io_y_pw,
    output logic        io_y_px,
    output logic        io_y_pr,
    output logic        io_y_ppp,
    output logic        io_y_pal,
    output logic        io_y_paa,
    output logic        io_y_eff,
    output logic        io_y_c
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PMA_WAIT = 2'd1,
        S_OUT      = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(PMA_TIMEOUT);

    state_t      state_q, state_d;
    logic        ae0_q;
    logic        accept, pma_done, pma_expired;

    logic [21:0] pteppn;
    logic [19:0] ppn_calc;
    logic        pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
    logic        bad, ae0_calc, ae_resp;

`ifdef PTW_ENTRY_BUILDER_TIMEOUT_EN
    logic [7:0]  wait_cnt_q;
    logic        unused_bits;
    assign unused_bits = ^{io_req_vpn[19:10], io_req_pte[9:8], io_req_pte[5]};
`else
    logic        unused_bits;
    assign unused_bits = ^{io_req_vpn[19:10], io_req_pte[9:8], io_req_pte[5], TIMEOUT_LIM};
`endif

    // Leaf decode; megapages take the low ppn bits from the vpn.
    always_comb begin
        pteppn   = io_req_pte[31:10];
        pte_v    = io_req_pte[0];
        pte_r    = io_req_pte[1];
        pte_w    = io_req_pte[2];
        pte_x    = io_req_pte[3];
        pte_a    = io_req_pte[6];
        pte_d    = io_req_pte[7];
        ppn_calc = io_req_level ? {pteppn[19:10], io_req_vpn[9:0]} : pteppn[19:0];
        ae0_calc = io_req_ae | (pteppn[21:20] != 2'b00);
        bad      = ~pte_v | (pte_w & ~pte_r) | (io_req_level & (pteppn[9:0] != 10'd0));
        ae_resp  = ae0_q | ~io_pma_resp_hit;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        pma_done    = 1'b0;
        pma_expired = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_req_valid) begin
                    accept  = 1'b1;
                    state_d = S_PMA_WAIT;
                end
            end
            S_PMA_WAIT: begin
                if (io_pma_resp_valid) begin
                    pma_done = 1'b1;
                    state_d  = S_OUT;
                end
`ifdef PTW_ENTRY_BUILDER_TIMEOUT_EN
                else if (({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_LIM) begin
                    pma_expired = 1'b1;
                    state_d     = S_OUT;
                end
`endif
            end
            S_OUT: begin
                if (io_y_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign io_req_ready     = (state_q == S_IDLE);
    assign io_pma_req_valid = (state_q == S_PMA_WAIT);
    assign io_y_valid       = (state_q == S_OUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ae0_q           <= 1'b0;
            io_pma_req_addr <= '0;
            io_y_ppn        <= '0;
            io_y_u          <= 1'b0;
            io_y_ae         <= 1'b0;
            io_y_sw         <= 1'b0;
            io_y_sx         <= 1'b0;
            io_y_sr         <= 1'b0;
            io_y_pw         <= 1'b0;
            io_y_px         <= 1'b0;
            io_y_pr         <= 1'b0;
            io_y_ppp        <= 1'b0;
            io_y_pal        <= 1'b0;
            io_y_paa        <= 1'b0;
            io_y_eff        <= 1'b0;
            io_y_c          <= 1'b0;
`ifdef PTW_ENTRY_BUILDER_TIMEOUT_EN
            wait_cnt_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Translation-side fields are final at accept; PMA-side fields land later.
            if (accept) begin
                ae0_q           <= ae0_calc;
                io_pma_req_addr <= {ppn_calc, 12'h000};
                io_y_ppn        <= ppn_calc;
                io_y_u          <= io_req_pte[4];
                io_y_sr         <= pte_r & pte_a & ~bad;
                io_y_sw         <= pte_w & pte_a & pte_d & ~bad;
                io_y_sx         <= pte_x & pte_a & ~bad;
            end
            if (pma_done) begin
                io_y_ae  <= ae_resp;
                io_y_pr  <= io_pma_resp_r & ~ae_resp;
                io_y_pw  <= io_pma_resp_w & ~ae_resp;
                io_y_px  <= io_pma_resp_x & ~ae_resp;
                io_y_ppp <= io_pma_resp_pp & io_pma_resp_hit;
                io_y_pal <= io_pma_resp_al & io_pma_resp_hit;
                io_y_paa <= io_pma_resp_aa & io_pma_resp_hit;
                io_y_eff <= io_pma_resp_eff & io_pma_resp_hit;
                io_y_c   <= io_pma_resp_c & io_pma_resp_hit;
            end
            if (pma_expired) begin
                io_y_ae  <= 1'b1;
                io_y_pr  <= 1'b0;
                io_y_pw  <= 1'b0;
                io_y_px  <= 1'b0;
                io_y_ppp <= 1'b0;
                io_y_pal <= 1'b0;
                io_y_paa <= 1'b0;
                io_y_eff <= 1'b0;
                io_y_c   <= 1'b0;
            end
`ifdef PTW_ENTRY_BUILDER_TIMEOUT_EN
            if (accept) begin
                wait_cnt_q <= '0;
            end else if ((state_q == S_PMA_WAIT) && !io_pma_resp_valid) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ptw_entry_builder.sv
// Directed bench for ptw_entry_builder: one task per scenario with inline hand-computed expectations.
module tb_ptw_entry_builder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [31:0] io_req_pte = '0;
    logic        io_req_level = 1'b0;
    logic [19:0] io_req_vpn = '0;
    logic        io_req_ae = 1'b0;
    logic        io_pma_req_valid;
    logic [31:0] io_pma_req_addr;
    logic        io_pma_resp_valid = 1'b0;
    logic        io_pma_resp_hit = 1'b0;
    logic        io_pma_resp_r = 1'b0, io_pma_resp_w = 1'b0, io_pma_resp_x = 1'b0;
    logic        io_pma_resp_pp = 1'b0, io_pma_resp_al = 1'b0, io_pma_resp_aa = 1'b0;
    logic        io_pma_resp_eff = 1'b0, io_pma_resp_c = 1'b0;
    logic        io_y_valid;
    logic        io_y_ready = 1'b1;
    logic [19:0] io_y_ppn;
    logic        io_y_u, io_y_ae, io_y_sw, io_y_sx, io_y_sr, io_y_pw, io_y_px, io_y_pr;
    logic        io_y_ppp, io_y_pal, io_y_paa, io_y_eff, io_y_c;

    int errors = 0;
    int checks = 0;

    // {u, ae, sw, sx, sr, pw, px, pr, ppp, pal, paa, eff, c}
    logic [12:0] yflags;
    assign yflags = {io_y_u, io_y_ae, io_y_sw, io_y_sx, io_y_sr, io_y_pw, io_y_px, io_y_pr,
                     io_y_ppp, io_y_pal, io_y_paa, io_y_eff, io_y_c};

    ptw_entry_builder #(.PMA_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_pte(io_req_pte),
        .io_req_level(io_req_level), .io_req_vpn(io_req_vpn), .io_req_ae(io_req_ae),
        .io_pma_req_valid(io_pma_req_valid), .io_pma_req_addr(io_pma_req_addr),
        .io_pma_resp_valid(io_pma_resp_valid), .io_pma_resp_hit(io_pma_resp_hit),
        .io_pma_resp_r(io_pma_resp_r), .io_pma_resp_w(io_pma_resp_w), .io_pma_resp_x(io_pma_resp_x),
        .io_pma_resp_pp(io_pma_resp_pp), .io_pma_resp_al(io_pma_resp_al), .io_pma_resp_aa(io_pma_resp_aa),
        .io_pma_resp_eff(io_pma_resp_eff), .io_pma_resp_c(io_pma_resp_c),
        .io_y_valid(io_y_valid), .io_y_ready(io_y_ready), .io_y_ppn(io_y_ppn),
        .io_y_u(io_y_u), .io_y_ae(io_y_ae), .io_y_sw(io_y_sw), .io_y_sx(io_y_sx), .io_y_sr(io_y_sr),
        .io_y_pw(io_y_pw), .io_y_px(io_y_px), .io_y_pr(io_y_pr), .io_y_ppp(io_y_ppp),
        .io_y_pal(io_y_pal), .io_y_paa(io_y_paa), .io_y_eff(io_y_eff), .io_y_c(io_y_c)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [31:0] pte, input logic lvl, input logic [19:0] vpn, input logic ae);
        io_req_pte   = pte;
        io_req_level = lvl;
        io_req_vpn   = vpn;
        io_req_ae    = ae;
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
    endtask

    // attr = {r, w, x, pp, al, aa, eff, c}
    task automatic set_resp(input logic hit, input logic [7:0] attr);
        io_pma_resp_hit = hit;
        {io_pma_resp_r, io_pma_resp_w, io_pma_resp_x, io_pma_resp_pp,
         io_pma_resp_al, io_pma_resp_aa, io_pma_resp_eff, io_pma_resp_c} = attr;
    endtask

    task automatic send_resp(input logic hit, input logic [7:0] attr);
        set_resp(hit, attr);
        io_pma_resp_valid = 1'b1;
        step();
        io_pma_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", io_req_ready); end
        checks++; if ({io_pma_req_valid, io_y_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b want 00", {io_pma_req_valid, io_y_valid}); end
        checks++; if (io_pma_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", io_pma_req_addr); end
        checks++; if ({io_y_ppn, yflags} !== 33'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {io_y_ppn, yflags}); end
    endtask

    task automatic test_4k_page();
        io_y_ready = 1'b1;
        send_req(32'h123450CF, 1'b0, 20'h00000, 1'b0);
        checks++; if ({io_pma_req_valid, io_y_valid, io_req_ready} !== 3'b100) begin errors++; $display("FAIL 4k_wait_state: got %b want 100", {io_pma_req_valid, io_y_valid, io_req_ready}); end
        checks++; if (io_pma_req_addr !== 32'h48D14000) begin errors++; $display("FAIL 4k_addr: got %h want 48d14000", io_pma_req_addr); end
        send_resp(1'b1, 8'b11100011);
        checks++; if ({io_y_valid, io_pma_req_valid} !== 2'b10) begin errors++; $display("FAIL 4k_out_state: got %b want 10", {io_y_valid, io_pma_req_valid}); end
        checks++; if (io_y_ppn !== 20'h48D14) begin errors++; $display("FAIL 4k_ppn: got %h want 48d14", io_y_ppn); end
        checks++; if (yflags !== 13'b0011111100011) begin errors++; $display("FAIL 4k_flags: got %b want 0011111100011", yflags); end
        step();
        checks++; if ({io_req_ready, io_y_valid} !== 2'b10) begin errors++; $display("FAIL 4k_back_idle: got %b want 10", {io_req_ready, io_y_valid}); end
    endtask

    task automatic test_megapage();
        // pte ppn 0x00400 keeps bit 10, low 10 bits come from vpn 0x2BC
        send_req(32'h00100043, 1'b1, 20'h00ABC, 1'b0);
        checks++; if (io_pma_req_addr !== 32'h006BC000) begin errors++; $display("FAIL mega_addr: got %h want 006bc000", io_pma_req_addr); end
        send_resp(1'b1, 8'b10000000);
        checks++; if (io_y_ppn !== 20'h006BC) begin errors++; $display("FAIL mega_ppn: got %h want 006bc", io_y_ppn); end
        checks++; if (yflags !== 13'b0000100100000) begin errors++; $display("FAIL mega_flags: got %b want 0000100100000", yflags); end
        step();
        send_req(32'h00100443, 1'b1, 20'h00ABC, 1'b0);
        send_resp(1'b1, 8'b10000000);
        checks++; if (io_y_ppn !== 20'h006BC) begin errors++; $display("FAIL mega_mis_ppn: got %h want 006bc", io_y_ppn); end
        checks++; if (yflags !== 13'b0000000100000) begin errors++; $display("FAIL mega_mis_flags: got %b want 0000000100000", yflags); end
        step();
    endtask

    task automatic test_reserved_and_high_ppn();
        // W without R, with U set
        send_req(32'h000040D5, 1'b0, 20'h0, 1'b0);
        send_resp(1'b1, 8'b11111100);
        checks++; if (yflags !== 13'b1000011111100) begin errors++; $display("FAIL wnr_flags: got %b want 1000011111100", yflags); end
        checks++; if (io_y_ppn !== 20'h00010) begin errors++; $display("FAIL wnr_ppn: got %h want 00010", io_y_ppn); end
        step();
        send_req(32'h400000CF, 1'b0, 20'h0, 1'b0);
        checks++; if (io_pma_req_addr !== 32'h0) begin errors++; $display("FAIL hippn_addr: got %h want 0", io_pma_req_addr); end
        send_resp(1'b1, 8'b11100000);
        checks++; if (yflags !== 13'b0111100000000) begin errors++; $display("FAIL hippn_flags: got %b want 0111100000000", yflags); end
        step();
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b1);
        send_resp(1'b1, 8'b11100011);
        checks++; if (yflags !== 13'b0111100000011) begin errors++; $display("FAIL req_ae_flags: got %b want 0111100000011", yflags); end
        step();
    endtask

    task automatic test_miss_backpressure();
        io_y_ready = 1'b0;
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b0);
        send_resp(1'b0, 8'b11111111);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({io_y_valid, io_req_ready} !== 2'b10) begin errors++; $display("FAIL bp_state[%0d]: got %b want 10", i, {io_y_valid, io_req_ready}); end
            checks++; if ({io_y_ppn, yflags} !== {20'h48D14, 13'b0111100000000}) begin errors++; $display("FAIL bp_fields[%0d]: got %h want %h", i, {io_y_ppn, yflags}, {20'h48D14, 13'b0111100000000}); end
            step();
        end
        io_y_ready = 1'b1;
        step();
        checks++; if ({io_req_ready, io_y_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b want 10", {io_req_ready, io_y_valid}); end
    endtask

    task automatic test_timeout();
        int n;
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b0);
`ifdef PTW_ENTRY_BUILDER_TIMEOUT_EN
        n = 0;
        while (io_pma_req_valid && n < 200) begin
            step();
            n++;
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
        checks++; if ({io_y_valid, yflags} !== {1'b1, 13'b0111100000000}) begin errors++; $display("FAIL timeout_entry: got %b want 10111100000000", {io_y_valid, yflags}); end
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (io_pma_req_valid && !io_y_valid) n++;
            step();
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL nowait_cycles: got %0d want 100", n); end
        send_resp(1'b1, 8'b10000000);
        checks++; if ({io_y_valid, yflags} !== {1'b1, 13'b0011100100000}) begin errors++; $display("FAIL late_entry: got %b want 10011100100000", {io_y_valid, yflags}); end
`endif
        step();
        checks++; if (io_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b want 1", io_req_ready); end
    endtask

    task automatic test_reset_midop();
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({io_req_ready, io_pma_req_valid, io_y_valid, io_pma_req_addr} !== {3'b100, 32'h0}) begin errors++; $display("FAIL rst_wait_state: got %h want %h", {io_req_ready, io_pma_req_valid, io_y_valid, io_pma_req_addr}, {3'b100, 32'h0}); end
        checks++; if ({io_y_ppn, yflags} !== 33'h0) begin errors++; $display("FAIL rst_wait_fields: got %h want 0", {io_y_ppn, yflags}); end
        send_req(32'h00100043, 1'b1, 20'h00ABC, 1'b0);
        send_resp(1'b1, 8'b10000000);
        checks++; if ({io_y_valid, io_y_ppn, yflags} !== {1'b1, 20'h006BC, 13'b0000100100000}) begin errors++; $display("FAIL rst_wait_next: got %h want %h", {io_y_valid, io_y_ppn, yflags}, {1'b1, 20'h006BC, 13'b0000100100000}); end
        step();
        io_y_ready = 1'b0;
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b0);
        send_resp(1'b1, 8'b11100011);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({io_req_ready, io_pma_req_valid, io_y_valid, io_pma_req_addr} !== {3'b100, 32'h0}) begin errors++; $display("FAIL rst_out_state: got %h want %h", {io_req_ready, io_pma_req_valid, io_y_valid, io_pma_req_addr}, {3'b100, 32'h0}); end
        checks++; if ({io_y_ppn, yflags} !== 33'h0) begin errors++; $display("FAIL rst_out_fields: got %h want 0", {io_y_ppn, yflags}); end
        step();
        checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL rst_out_no_entry: got %b want 0", io_y_valid); end
        io_y_ready = 1'b1;
        send_req(32'h123450CF, 1'b0, 20'h0, 1'b0);
        send_resp(1'b1, 8'b11100011);
        checks++; if ({io_y_valid, io_y_ppn, yflags} !== {1'b1, 20'h48D14, 13'b0011111100011}) begin errors++; $display("FAIL rst_out_next: got %h want %h", {io_y_valid, io_y_ppn, yflags}, {1'b1, 20'h48D14, 13'b0011111100011}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] rdy_seen, vld_seen;
        io_req_pte   = 32'h123450CF;
        io_req_level = 1'b0;
        io_req_ae    = 1'b0;
        set_resp(1'b1, 8'b11100011);
        io_y_ready        = 1'b1;
        io_req_valid      = 1'b1;
        io_pma_resp_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rdy_seen[i] = io_req_ready;
            vld_seen[i] = io_y_valid;
            if (i < 6) step();
        end
        io_req_valid      = 1'b0;
        io_pma_resp_valid = 1'b0;
        checks++; if (rdy_seen !== 7'b1001001) begin errors++; $display("FAIL b2b_ready: got %b want 1001001", rdy_seen); end
        checks++; if (vld_seen !== 7'b0100100) begin errors++; $display("FAIL b2b_valid: got %b want 0100100", vld_seen); end
        step();
        checks++; if ({io_req_ready, io_y_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle: got %b want 10", {io_req_ready, io_y_valid}); end
    endtask

    initial begin
        test_reset();
        test_4k_page();
        test_megapage();
        test_reserved_and_high_ppn();
        test_miss_backpressure();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
